// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side handshakes and mem_access control/data signals
// shared by mem_arbiter and its neighbours.
interface mem_arbiter_if;
    // Instruction-fetch requester
    logic        if_req;
    logic        if_gnt;
    logic        if_done;
    logic [7:0]  if_data;

    // Data requester
    logic        dm_req;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [7:0]  dm_wdata;
    logic        dm_gnt;
    logic        dm_done;
    logic [7:0]  dm_rdata;

    // mem_access controls and data
    logic        mem_en;
    logic        mem_pc_data;
    logic        mem_w_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic        busy;

    // Arbiter view
    modport slave (
        input  if_req,
        input  dm_req,
        input  dm_we,
        input  dm_addr,
        input  dm_wdata,
        input  mem_rdata,
        output if_gnt,
        output if_done,
        output if_data,
        output dm_gnt,
        output dm_done,
        output dm_rdata,
        output mem_en,
        output mem_pc_data,
        output mem_w_rd,
        output mem_addr,
        output mem_wdata,
        output busy
    );

    // Requester / memory-model view
    modport master (
        output if_req,
        output dm_req,
        output dm_we,
        output dm_addr,
        output dm_wdata,
        output mem_rdata,
        input  if_gnt,
        input  if_done,
        input  if_data,
        input  dm_gnt,
        input  dm_done,
        input  dm_rdata,
        input  mem_en,
        input  mem_pc_data,
        input  mem_w_rd,
        input  mem_addr,
        input  mem_wdata,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester sequencer/arbiter for the single mem_access port; all outputs registered.
// Define MEM_ARB_RR_EN for round-robin arbitration (default: data over fetch).
module mem_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2  // legal range 1..15
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StAccess = 1'b1;

    localparam logic OwnFetch = 1'b0;
    localparam logic OwnData  = 1'b1;

    localparam logic [3:0] CntLoad = 4'(ACCESS_CYCLES - 1);

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  if_data_q, if_data_d;
    logic [7:0]  dm_rdata_q, dm_rdata_d;
    logic        if_gnt_q, if_gnt_d;
    logic        dm_gnt_q, dm_gnt_d;
    logic        if_done_q, if_done_d;
    logic        dm_done_q, dm_done_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_pc_data_q, mem_pc_data_d;
    logic        mem_w_rd_q, mem_w_rd_d;
    logic        pick_data;

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;  // requester served most recently (OwnFetch/OwnData)

    // On a tie, the requester not served last wins; a lone requester always wins.
    assign pick_data = bus.dm_req && (!bus.if_req || (last_q == OwnFetch));
`else
    assign pick_data = bus.dm_req;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_data_d  = if_data_q;
        dm_rdata_d = dm_rdata_q;
        if_gnt_d   = 1'b0;
        dm_gnt_d   = 1'b0;
        if_done_d  = 1'b0;
        dm_done_d  = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_d     = last_q;
`endif

        case (state_q)
            StIdle: begin
                if (bus.if_req || bus.dm_req) begin
                    state_d = StAccess;
                    cnt_d   = CntLoad;
                    if (pick_data) begin
                        owner_d  = OwnData;
                        we_d     = bus.dm_we;
                        addr_d   = bus.dm_addr;
                        wdata_d  = bus.dm_wdata;
                        dm_gnt_d = 1'b1;
                    end else begin
                        owner_d  = OwnFetch;
                        if_gnt_d = 1'b1;
                    end
`ifdef MEM_ARB_RR_EN
                    last_d = pick_data ? OwnData : OwnFetch;
`endif
                end
            end
            StAccess: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Final edge of the access: sample read data and signal completion.
                    state_d = StIdle;
                    if (owner_q == OwnData) begin
                        dm_done_d = 1'b1;
                        if (!we_q) begin
                            dm_rdata_d = bus.mem_rdata;
                        end
                    end else begin
                        if_done_d = 1'b1;
                        if_data_d = bus.mem_rdata;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Memory controls are registered from the next state so they line up with ACCESS.
        mem_en_d      = (state_d == StAccess);
        mem_pc_data_d = mem_en_d && (owner_d == OwnFetch);
        mem_w_rd_d    = mem_en_d && ((owner_d == OwnFetch) || !we_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= 4'd0;
            owner_q       <= OwnFetch;
            we_q          <= 1'b0;
            addr_q        <= 16'h0000;
            wdata_q       <= 8'h00;
            if_data_q     <= 8'h00;
            dm_rdata_q    <= 8'h00;
            if_gnt_q      <= 1'b0;
            dm_gnt_q      <= 1'b0;
            if_done_q     <= 1'b0;
            dm_done_q     <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_pc_data_q <= 1'b0;
            mem_w_rd_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            owner_q       <= owner_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            if_data_q     <= if_data_d;
            dm_rdata_q    <= dm_rdata_d;
            if_gnt_q      <= if_gnt_d;
            dm_gnt_q      <= dm_gnt_d;
            if_done_q     <= if_done_d;
            dm_done_q     <= dm_done_d;
            mem_en_q      <= mem_en_d;
            mem_pc_data_q <= mem_pc_data_d;
            mem_w_rd_q    <= mem_w_rd_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= OwnFetch;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign bus.if_gnt      = if_gnt_q;
    assign bus.if_done     = if_done_q;
    assign bus.if_data     = if_data_q;
    assign bus.dm_gnt      = dm_gnt_q;
    assign bus.dm_done     = dm_done_q;
    assign bus.dm_rdata    = dm_rdata_q;
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_pc_data = mem_pc_data_q;
    assign bus.mem_w_rd    = mem_w_rd_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.busy        = (state_q == StAccess);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: one instance with ACCESS_CYCLES=2,
// one with ACCESS_CYCLES=1 for the single-cycle boundary.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_arbiter_if a_bus ();
    mem_arbiter_if b_bus ();

    mem_arbiter #(.ACCESS_CYCLES(2)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_bus.slave)
    );

    mem_arbiter #(.ACCESS_CYCLES(1)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic exp_data_win [3];

    initial begin
        a_bus.if_req = 1'b0; a_bus.dm_req = 1'b0; a_bus.dm_we = 1'b0;
        a_bus.dm_addr = 16'h0; a_bus.dm_wdata = 8'h0; a_bus.mem_rdata = 8'h0;
        b_bus.if_req = 1'b0; b_bus.dm_req = 1'b0; b_bus.dm_we = 1'b0;
        b_bus.dm_addr = 16'h0; b_bus.dm_wdata = 8'h0; b_bus.mem_rdata = 8'h0;

        // Reset state
        tick();
        tick();
        check("rst_mem_en",   32'(a_bus.mem_en), 0);
        check("rst_busy",     32'(a_bus.busy), 0);
        check("rst_if_data",  32'(a_bus.if_data), 0);
        check("rst_dm_rdata", 32'(a_bus.dm_rdata), 0);
        check("rst_mem_addr", 32'(a_bus.mem_addr), 0);
        check("rst_gnt",      32'({a_bus.if_gnt, a_bus.dm_gnt}), 0);
        rst = 1'b0;

        // Fetch read
        a_bus.if_req = 1'b1;
        a_bus.mem_rdata = 8'hA5;
        tick();
        check("fetch_gnt",   32'(a_bus.if_gnt), 1);
        check("fetch_ctl0",  32'({a_bus.mem_en, a_bus.mem_pc_data, a_bus.mem_w_rd}), 32'h7);
        check("fetch_busy",  32'(a_bus.busy), 1);
        a_bus.if_req = 1'b0;
        tick();
        check("fetch_gnt_pulse", 32'(a_bus.if_gnt), 0);
        check("fetch_ctl1",  32'({a_bus.mem_en, a_bus.mem_pc_data, a_bus.mem_w_rd}), 32'h7);
        check("fetch_done_early", 32'(a_bus.if_done), 0);
        tick();
        check("fetch_ctl_idle", 32'({a_bus.mem_en, a_bus.mem_pc_data, a_bus.mem_w_rd}), 0);
        check("fetch_done",  32'(a_bus.if_done), 1);
        check("fetch_data",  32'(a_bus.if_data), 32'hA5);
        tick();
        check("fetch_done_pulse", 32'(a_bus.if_done), 0);
        check("fetch_data_hold",  32'(a_bus.if_data), 32'hA5);

        // Data write, inputs scrambled right after grant
        a_bus.dm_req = 1'b1; a_bus.dm_we = 1'b1;
        a_bus.dm_addr = 16'h1234; a_bus.dm_wdata = 8'h5A; a_bus.mem_rdata = 8'h3C;
        tick();
        check("wr_gnt",   32'(a_bus.dm_gnt), 1);
        check("wr_ctl0",  32'({a_bus.mem_en, a_bus.mem_pc_data, a_bus.mem_w_rd}), 32'h4);
        check("wr_addr0", 32'(a_bus.mem_addr), 32'h1234);
        check("wr_wdata0", 32'(a_bus.mem_wdata), 32'h5A);
        a_bus.dm_req = 1'b0; a_bus.dm_we = 1'b0;
        a_bus.dm_addr = 16'hFFFF; a_bus.dm_wdata = 8'h00;
        tick();
        check("wr_ctl1",  32'({a_bus.mem_en, a_bus.mem_pc_data, a_bus.mem_w_rd}), 32'h4);
        check("wr_addr1", 32'(a_bus.mem_addr), 32'h1234);
        check("wr_wdata1", 32'(a_bus.mem_wdata), 32'h5A);
        tick();
        check("wr_done",   32'(a_bus.dm_done), 1);
        check("wr_rdata",  32'(a_bus.dm_rdata), 0);
        check("wr_mem_en", 32'(a_bus.mem_en), 0);
        check("wr_addr_hold", 32'(a_bus.mem_addr), 32'h1234);

        // Data read
        a_bus.dm_req = 1'b1; a_bus.dm_we = 1'b0;
        a_bus.dm_addr = 16'h0042; a_bus.mem_rdata = 8'h77;
        tick();
        check("rd_gnt",  32'(a_bus.dm_gnt), 1);
        check("rd_ctl0", 32'({a_bus.mem_en, a_bus.mem_pc_data, a_bus.mem_w_rd}), 32'h5);
        check("rd_addr", 32'(a_bus.mem_addr), 32'h0042);
        a_bus.dm_req = 1'b0;
        tick();
        tick();
        check("rd_done",  32'(a_bus.dm_done), 1);
        check("rd_rdata", 32'(a_bus.dm_rdata), 32'h77);
        check("rd_if_data_hold", 32'(a_bus.if_data), 32'hA5);

        // Contention: both held. Last served so far was data.
`ifdef MEM_ARB_RR_EN
        exp_data_win[0] = 1'b0; exp_data_win[1] = 1'b1; exp_data_win[2] = 1'b0;
`else
        exp_data_win[0] = 1'b1; exp_data_win[1] = 1'b1; exp_data_win[2] = 1'b1;
`endif
        a_bus.if_req = 1'b1; a_bus.dm_req = 1'b1; a_bus.dm_we = 1'b0;
        a_bus.mem_rdata = 8'h11;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("cont_dm_gnt%0d", i), 32'(a_bus.dm_gnt), 32'(exp_data_win[i]));
            check($sformatf("cont_if_gnt%0d", i), 32'(a_bus.if_gnt), 32'(!exp_data_win[i]));
            tick();
            tick();
            check($sformatf("cont_done%0d", i), 32'({a_bus.dm_done, a_bus.if_done}),
                  exp_data_win[i] ? 32'h2 : 32'h1);
            check($sformatf("cont_idle%0d", i), 32'(a_bus.mem_en), 0);
        end
        a_bus.if_req = 1'b0; a_bus.dm_req = 1'b0;
        tick();
        check("cont_quiet", 32'({a_bus.mem_en, a_bus.if_gnt, a_bus.dm_gnt}), 0);

        // Reset mid-access (cnt == 1 in the cycle after grant)
        a_bus.if_req = 1'b1; a_bus.mem_rdata = 8'hEE;
        tick();
        check("mid_gnt", 32'(a_bus.if_gnt), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_mem_en_async", 32'(a_bus.mem_en), 0);
        check("mid_busy",     32'(a_bus.busy), 0);
        check("mid_if_data",  32'(a_bus.if_data), 0);
        check("mid_dm_rdata", 32'(a_bus.dm_rdata), 0);
        tick();
        check("mid_no_done", 32'({a_bus.if_done, a_bus.dm_done}), 0);
        rst = 1'b0;
        tick();
        check("mid_regrant", 32'(a_bus.if_gnt), 1);
        check("mid_regrant_en", 32'(a_bus.mem_en), 1);
        a_bus.if_req = 1'b0;
        tick();
        tick();
        check("mid_done", 32'(a_bus.if_done), 1);
        check("mid_data", 32'(a_bus.if_data), 32'hEE);

        // ACCESS_CYCLES = 1 with if_req held: mem_en 1,0,1,0 and done every second cycle
        b_bus.if_req = 1'b1; b_bus.mem_rdata = 8'h5C;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("ac1_mem_en%0d", i), 32'(b_bus.mem_en), (i % 2 == 0) ? 1 : 0);
            check($sformatf("ac1_done%0d", i), 32'(b_bus.if_done), (i % 2 == 1) ? 1 : 0);
        end
        check("ac1_data", 32'(b_bus.if_data), 32'h5C);
        b_bus.if_req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
